// File: rtl/miv_ram_scrub_arb.sv
// miv_ram_scrub_arb: host/background-scrub arbiter for a 2048x32 ECC RAM with error counters.
// The background scrubber is built only when MIV_RAM_SCRUB_EN is defined.
module miv_ram_scrub_arb #(
  parameter int unsigned SCRUB_INTERVAL = 1024
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        HREQ,
  input  logic        HWE,
  input  logic [10:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HGNT,
  output logic        HRVALID,
  output logic [31:0] HRDATA,
  output logic        HRERR,
  output logic [31:0] RAM_WD,
  output logic [10:0] RAM_WADDR,
  output logic [10:0] RAM_RADDR,
  output logic        RAM_WEN,
  input  logic [31:0] RAM_RD,
  input  logic        RAM_SB_CORRECT,
  input  logic        RAM_DB_DETECT,
  input  logic        CNT_CLR,
  output logic [15:0] SB_CNT,
  output logic [15:0] DB_CNT,
  output logic        DB_IRQ
);

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  if (SCRUB_INTERVAL < 4 || SCRUB_INTERVAL > 65535) begin : g_bad_interval
    $error("SCRUB_INTERVAL must be within 4..65535");
  end

  logic          hgnt_c;
  logic          host_rd_c;
  logic          host_wr_c;
  logic          scrub_chk_c;
  logic          rd_check_c;
  logic          hvalid_q, hvalid_d;
  logic [CW-1:0] sb_cnt_q, sb_cnt_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          db_irq_q, db_irq_d;

  assign host_rd_c = hgnt_c & ~HWE;
  assign host_wr_c = hgnt_c & HWE;

`ifdef MIV_RAM_SCRUB_EN
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SCRUB_RD = 2'd1;
  localparam logic [1:0] ST_SCRUB_CHK = 2'd2;
  localparam logic [1:0] ST_SCRUB_WB = 2'd3;
  localparam logic [CW-1:0] IVL_LAST = CW'(SCRUB_INTERVAL - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] scrub_addr_q, scrub_addr_d;
  logic [CW-1:0] ivl_q, ivl_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          scrub_rd_c;
  logic          scrub_wb_c;

  assign scrub_rd_c  = (state_q == ST_SCRUB_RD) & ~HREQ;
  assign scrub_wb_c  = (state_q == ST_SCRUB_WB);
  assign scrub_chk_c = (state_q == ST_SCRUB_CHK);
  assign hgnt_c      = HREQ & ~scrub_wb_c;

  // Scrub sequencing; a host write to the word under check makes the write-back stale.
  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    ivl_d        = ivl_q;
    wb_data_d    = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ivl_q == IVL_LAST) begin
          state_d = ST_SCRUB_RD;
          ivl_d   = '0;
        end else begin
          ivl_d = ivl_q + CW'(1);
        end
      end
      ST_SCRUB_RD: begin
        if (!HREQ) state_d = ST_SCRUB_CHK;
      end
      ST_SCRUB_CHK: begin
        if (RAM_SB_CORRECT && !(host_wr_c && (HADDR == scrub_addr_q))) begin
          state_d   = ST_SCRUB_WB;
          wb_data_d = RAM_RD;
        end else begin
          state_d      = ST_IDLE;
          scrub_addr_d = scrub_addr_q + AW'(1);
        end
      end
      ST_SCRUB_WB: begin
        state_d      = ST_IDLE;
        scrub_addr_d = scrub_addr_q + AW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      scrub_addr_q <= '0;
      ivl_q        <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      ivl_q        <= ivl_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign RAM_RADDR = scrub_rd_c ? scrub_addr_q : HADDR;
  assign RAM_WADDR = scrub_wb_c ? scrub_addr_q : HADDR;
  assign RAM_WD    = scrub_wb_c ? wb_data_q : HWDATA;
  assign RAM_WEN   = RESETN & (scrub_wb_c | host_wr_c);
`else
  assign hgnt_c      = HREQ;
  assign scrub_chk_c = 1'b0;
  assign RAM_RADDR   = HADDR;
  assign RAM_WADDR   = HADDR;
  assign RAM_WD      = HWDATA;
  assign RAM_WEN     = RESETN & host_wr_c;
`endif

  // RAM flags are meaningful only in the cycle after a host or scrub read.
  assign rd_check_c = hvalid_q | scrub_chk_c;

  always_comb begin
    hvalid_d = host_rd_c;
    sb_cnt_d = sb_cnt_q;
    db_cnt_d = db_cnt_q;
    db_irq_d = db_irq_q;
    if (CNT_CLR) begin
      sb_cnt_d = '0;
      db_cnt_d = '0;
      db_irq_d = 1'b0;
    end else begin
      if (rd_check_c && RAM_SB_CORRECT && (sb_cnt_q != CNT_MAX)) sb_cnt_d = sb_cnt_q + CW'(1);
      if (rd_check_c && RAM_DB_DETECT && (db_cnt_q != CNT_MAX)) db_cnt_d = db_cnt_q + CW'(1);
      if (rd_check_c && RAM_DB_DETECT) db_irq_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hvalid_q <= 1'b0;
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
      db_irq_q <= 1'b0;
    end else begin
      hvalid_q <= hvalid_d;
      sb_cnt_q <= sb_cnt_d;
      db_cnt_q <= db_cnt_d;
      db_irq_q <= db_irq_d;
    end
  end

  assign HGNT    = hgnt_c;
  assign HRVALID = hvalid_q;
  assign HRDATA  = hvalid_q ? RAM_RD : '0;
  assign HRERR   = hvalid_q & RAM_DB_DETECT;
  assign SB_CNT  = sb_cnt_q;
  assign DB_CNT  = db_cnt_q;
  assign DB_IRQ  = db_irq_q;

endmodule

// File: doc/miv_ram_scrub_arb.md
MIV_RAM_SCRUB_ARB -- requirements
Module: miv_ram_scrub_arb

Interface
REQ-001 SHALL have parameter SCRUB_INTERVAL, default 1024: idle cycles between background scrub reads, legal range 4..65535.
REQ-002 SHALL have ports (name / direction / width / meaning):
- CLK in 1: single clock.
- RESETN in 1: reset, asynchronous, active-low.
- HREQ in 1: host request; held until granted.
- HWE in 1: host write (1) or read (0).
- HADDR in 11: host word address.
- HWDATA in 32: host write data.
- HGNT out 1: host request accepted this cycle.
- HRVALID out 1: host read data valid.
- HRDATA out 32: host read data.
- HRERR out 1: double-bit error on host read.
- RAM_WD out 32: RAM write data.
- RAM_WADDR out 11: RAM write address.
- RAM_RADDR out 11: RAM read address.
- RAM_WEN out 1: RAM write enable.
- RAM_RD in 32: RAM read data.
- RAM_SB_CORRECT in 1: RAM single-bit-corrected flag.
- RAM_DB_DETECT in 1: RAM double-bit-detected flag.
- CNT_CLR in 1: clear counters and IRQ.
- SB_CNT out 16: corrected-error count.
- DB_CNT out 16: uncorrectable-error count.
- DB_IRQ out 1: sticky double-bit interrupt.
REQ-003 SHALL treat the one-clock, asynchronous active-low RESETN scheme as already decided.

Function
REQ-004 SHALL issue at most one RAM operation per cycle; RAM_WEN and a flagged read are never issued in the same cycle.
REQ-005 RAM read latency SHALL be 1 cycle: RAM_RD and the flags sampled in cycle t+1 belong to the read issued in cycle t.
REQ-006 Priority SHALL be: pending scrub write-back > host > scrub read.
REQ-007 HGNT SHALL be combinational: HREQ & not (state == SCRUB_WB).
- Host stall per write-back: 1 cycle maximum.
REQ-008 A granted host write SHALL drive RAM_WEN=1, RAM_WADDR=HADDR and RAM_WD=HWDATA in the grant cycle.
REQ-009 A granted host read SHALL assert HRVALID with HRDATA=RAM_RD exactly 1 cycle after grant.
- In that same cycle, HRERR SHALL equal RAM_DB_DETECT.
REQ-010 The scrub FSM SHALL have states IDLE, SCRUB_RD, SCRUB_CHK and SCRUB_WB.
- IDLE -> SCRUB_RD: when the interval counter reaches SCRUB_INTERVAL-1.
- SCRUB_RD -> SCRUB_CHK: when HREQ=0; the read of scrub_addr is issued that cycle. Otherwise the FSM stays in SCRUB_RD.
- SCRUB_CHK -> SCRUB_WB: when RAM_SB_CORRECT=1; RAM_RD is latched as the corrected word.
- SCRUB_CHK -> IDLE: otherwise.
- SCRUB_WB -> IDLE: after writing the latched word to scrub_addr.
- On every return to IDLE, scrub_addr SHALL increment, wrapping 2047 -> 0.
REQ-011 A host write to scrub_addr granted in the SCRUB_RD-issue cycle SHALL NOT occur (per REQ-004). A host write to scrub_addr granted while in SCRUB_CHK SHALL cancel the write-back (SCRUB_CHK -> IDLE).
REQ-012 The interval counter SHALL count only in IDLE and SHALL reset to 0 on leaving IDLE.
REQ-013 SB_CNT and DB_CNT SHALL increment on RAM_SB_CORRECT and RAM_DB_DETECT respectively, for both host and scrub reads.
- Both counters SHALL saturate at 0xFFFF.
REQ-014 DB_IRQ SHALL set on any DB detection and hold until CNT_CLR.
REQ-015 If CNT_CLR and an increment fall in the same cycle, clear SHALL win (counter = 0, DB_IRQ = 0).
REQ-016 Scrub double-bit detections SHALL be counted but never written back.

Reset
REQ-017 While RESETN=0, the block SHALL hold:
- FSM = IDLE; scrub_addr, interval counter, SB_CNT, DB_CNT = 0.
- DB_IRQ, HRVALID, HRERR, RAM_WEN = 0.
- HRDATA = 0.
REQ-018 Reset asserted mid-operation SHALL drop any pending write-back and any in-flight host read, with no HRVALID afterwards.

Configuration
REQ-019 Macro MIV_RAM_SCRUB_EN:
- Defined: scrubber per REQ-010..REQ-012.
- Undefined: FSM and interval counter are absent; HGNT=HREQ; no scrub operations; counters and IRQ count host reads only; port list is unchanged.

Verification
REQ-020 Host write 0x2000_0000 to address 5, then read address 5 -> HRVALID one cycle after grant, HRDATA=0x2000_0000, HRERR=0.
REQ-021 Inject single-bit error at address 7, SCRUB_INTERVAL=4, let the scrub reach 7 -> SB_CNT=1 and one RAM_WEN to address 7 with corrected data; a rescrub gives SB_CNT unchanged.
REQ-022 Double-bit error at address 9, host read -> HRERR=1, DB_CNT=1, DB_IRQ=1; no write-back; CNT_CLR -> DB_CNT=0, DB_IRQ=0.
REQ-023 HREQ held high continuously during a pending write-back -> HGNT=0 for exactly 1 cycle; host write to the scrub address in SCRUB_CHK -> no write-back, host data retained.
REQ-024 Scrub from address 2047 -> next scrub read at 0; SB_CNT preloaded to 0xFFFF plus an SB event -> stays 0xFFFF; RESETN pulsed in SCRUB_WB -> no RAM_WEN, scrub_addr=0.
